// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, opcode encoding, EX FSM states, immediate sign-extension.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package core_pkg;

    localparam int DATA_W    = 16;
    localparam int IMM_W     = 7;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 4;
    localparam int MUL_CYC   = 16;

    // Opcode encoding carried from ID through WB; 14 and 15 are unused and behave as NOP.
    localparam logic [CTRL_W-1:0] OP_NOP  = 4'd0;
    localparam logic [CTRL_W-1:0] OP_ADD  = 4'd1;
    localparam logic [CTRL_W-1:0] OP_SUB  = 4'd2;
    localparam logic [CTRL_W-1:0] OP_AND  = 4'd3;
    localparam logic [CTRL_W-1:0] OP_OR   = 4'd4;
    localparam logic [CTRL_W-1:0] OP_XOR  = 4'd5;
    localparam logic [CTRL_W-1:0] OP_SLL  = 4'd6;
    localparam logic [CTRL_W-1:0] OP_SRL  = 4'd7;
    localparam logic [CTRL_W-1:0] OP_ADDI = 4'd8;
    localparam logic [CTRL_W-1:0] OP_LW   = 4'd9;
    localparam logic [CTRL_W-1:0] OP_SW   = 4'd10;
    localparam logic [CTRL_W-1:0] OP_BEQ  = 4'd11;
    localparam logic [CTRL_W-1:0] OP_BNE  = 4'd12;
    localparam logic [CTRL_W-1:0] OP_MUL  = 4'd13;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_t;

    // Side-band fields of a MUL that must survive until its product is written to the output stage.
    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [DATA_W-1:0]    reg2;
    } mul_meta_t;

    function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/mul16_serial.sv
// Serial shift-add multiplier, low DATA_W bits of a*b, one partial product per cycle.
// Latency: start cycle latches operands, then N_CYC iterations; product is final after the done cycle.
// Backpressure: none; product holds after completion until the next start or reset.
module mul16_serial
    import core_pkg::*;
#(
    parameter int N_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(N_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;

    // done marks the cycle in which the final partial product is being added.
    assign done    = busy && (cnt == CNT_LAST);
    assign product = acc;

    // Iteration: add shifted multiplicand when the current multiplier bit is set; zero operands still run all cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: registers ID operands, ALU/address/branch resolution, serial MUL via mul16_serial.
// Latency: 1 cycle for non-MUL ops; MUL result 17 cycles after accept when MA is ready.
// Backpressure: ex_ready = idle & (!ex_valid | ma_ready); outputs hold while ex_valid & !ma_ready.
module execute_stage
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 ex_ready,
    input  logic [DATA_W-1:0]    NPC_ID,
    input  logic [DATA_W-1:0]    REG1_DATA_ID,
    input  logic [DATA_W-1:0]    REG2_DATA_ID,
    input  logic [REG_IDX_W-1:0] DEST_REG_INDEX_ID,
    input  logic [IMM_W-1:0]     IMMEDIATE_ID,
    input  logic [CTRL_W-1:0]    CTRL_ID,
    input  logic                 ma_ready,
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    RES_EX,
    output logic [DATA_W-1:0]    REG_DATA_EX,
    output logic [REG_IDX_W-1:0] DEST_REG_INDEX_EX,
    output logic [CTRL_W-1:0]    CTRL_EX,
    output logic [DATA_W-1:0]    TARGET,
    output logic                 TARGET_EN
);

    ex_state_t         state;
    mul_meta_t         mul_meta;

    logic              ld;
    logic              accept;
    logic              accept_mul;
    logic              accept_alu;
    logic              is_branch;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] alu_res;
    logic              br_taken;
    logic [CTRL_W-1:0] ctrl_fwd;

    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign ld         = !ex_valid || ma_ready;
    assign ex_ready   = (state == EX_IDLE) && ld;
    assign accept     = id_valid && ex_ready;
    assign accept_mul = accept && (CTRL_ID == OP_MUL);
    assign accept_alu = accept && (CTRL_ID != OP_MUL);
    assign is_branch  = (CTRL_ID == OP_BEQ) || (CTRL_ID == OP_BNE);

    mul16_serial #(
        .N_CYC (MUL_CYC)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept_mul),
        .a       (REG1_DATA_ID),
        .b       (REG2_DATA_ID),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle ALU, address and branch resolution; branches also report their target on RES_EX.
    always_comb begin
        imm_ext   = sext(IMMEDIATE_ID);
        br_target = NPC_ID + imm_ext;
        br_taken  = 1'b0;
        alu_res   = '0;
        ctrl_fwd  = CTRL_ID;
        case (CTRL_ID)
            OP_ADD:  alu_res = REG1_DATA_ID + REG2_DATA_ID;
            OP_SUB:  alu_res = REG1_DATA_ID - REG2_DATA_ID;
            OP_AND:  alu_res = REG1_DATA_ID & REG2_DATA_ID;
            OP_OR:   alu_res = REG1_DATA_ID | REG2_DATA_ID;
            OP_XOR:  alu_res = REG1_DATA_ID ^ REG2_DATA_ID;
            OP_SLL:  alu_res = REG1_DATA_ID << REG2_DATA_ID[3:0];
            OP_SRL:  alu_res = REG1_DATA_ID >> REG2_DATA_ID[3:0];
            OP_ADDI,
            OP_LW,
            OP_SW:   alu_res = REG1_DATA_ID + imm_ext;
            OP_BEQ: begin
                alu_res  = br_target;
                br_taken = (REG1_DATA_ID == REG2_DATA_ID);
            end
            OP_BNE: begin
                alu_res  = br_target;
                br_taken = (REG1_DATA_ID != REG2_DATA_ID);
            end
            OP_MUL:  alu_res = '0;
            default: begin
                alu_res  = '0;
                ctrl_fwd = OP_NOP;
            end
        endcase
    end

    // MUL sequencing: latch side-band on accept, wait out the multiplier, hand the product over once the output stage frees.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EX_IDLE;
            mul_meta <= '0;
        end else begin
            case (state)
                EX_IDLE: begin
                    if (accept_mul) begin
                        state         <= EX_BUSY;
                        mul_meta.dest <= DEST_REG_INDEX_ID;
                        mul_meta.reg2 <= REG2_DATA_ID;
                    end
                end
                EX_BUSY: begin
                    if (mul_busy && mul_done) begin
                        state <= EX_DONE;
                    end
                end
                EX_DONE: begin
                    if (ld) begin
                        state <= EX_IDLE;
                    end
                end
                default: state <= EX_IDLE;
            endcase
        end
    end

    // Output stage: load on ld from either a fresh ALU op or a finished MUL, otherwise drain; redirect pulse is independent of ld.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid          <= 1'b0;
            RES_EX            <= '0;
            REG_DATA_EX       <= '0;
            DEST_REG_INDEX_EX <= '0;
            CTRL_EX           <= '0;
            TARGET            <= '0;
            TARGET_EN         <= 1'b0;
        end else begin
            TARGET_EN <= accept_alu && br_taken;
            if (accept_alu && is_branch) begin
                TARGET <= br_target;
            end
            if (ld) begin
                if (accept_alu) begin
                    ex_valid          <= 1'b1;
                    RES_EX            <= alu_res;
                    REG_DATA_EX       <= REG2_DATA_ID;
                    DEST_REG_INDEX_EX <= DEST_REG_INDEX_ID;
                    CTRL_EX           <= ctrl_fwd;
                end else if (state == EX_DONE) begin
                    ex_valid          <= 1'b1;
                    RES_EX            <= mul_product;
                    REG_DATA_EX       <= mul_meta.reg2;
                    DEST_REG_INDEX_EX <= mul_meta.dest;
                    CTRL_EX           <= OP_MUL;
                end else begin
                    ex_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a transaction-level reference model and hand-computed vectors.
// Latency: n/a.
// Backpressure: bench drives ma_ready directly to exercise stalls.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        ex_ready;
    logic [15:0] NPC_ID;
    logic [15:0] REG1_DATA_ID;
    logic [15:0] REG2_DATA_ID;
    logic [4:0]  DEST_REG_INDEX_ID;
    logic [6:0]  IMMEDIATE_ID;
    logic [3:0]  CTRL_ID;
    logic        ma_ready;
    logic        ex_valid;
    logic [15:0] RES_EX;
    logic [15:0] REG_DATA_EX;
    logic [4:0]  DEST_REG_INDEX_EX;
    logic [3:0]  CTRL_EX;
    logic [15:0] TARGET;
    logic        TARGET_EN;

    int n_tests = 0;
    int n_fail  = 0;

    execute_stage dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .ex_ready          (ex_ready),
        .NPC_ID            (NPC_ID),
        .REG1_DATA_ID      (REG1_DATA_ID),
        .REG2_DATA_ID      (REG2_DATA_ID),
        .DEST_REG_INDEX_ID (DEST_REG_INDEX_ID),
        .IMMEDIATE_ID      (IMMEDIATE_ID),
        .CTRL_ID           (CTRL_ID),
        .ma_ready          (ma_ready),
        .ex_valid          (ex_valid),
        .RES_EX            (RES_EX),
        .REG_DATA_EX       (REG_DATA_EX),
        .DEST_REG_INDEX_EX (DEST_REG_INDEX_EX),
        .CTRL_EX           (CTRL_EX),
        .TARGET            (TARGET),
        .TARGET_EN         (TARGET_EN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one instruction, from the opcode table with plain integer arithmetic.
    function automatic void golden(input int op, input int a, input int b, input int imm7, input int npc,
                                   output int res, output int ctrl, output int tgt, output bit taken);
        int s;
        longint p;
        s     = (imm7 >= 64) ? imm7 - 128 : imm7;
        tgt   = (npc + s) & 32'hFFFF;
        taken = 1'b0;
        ctrl  = op;
        res   = 0;
        case (op)
            1:  res = (a + b) & 32'hFFFF;
            2:  res = (a - b) & 32'hFFFF;
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  res = (a << (b % 16)) & 32'hFFFF;
            7:  res = a >> (b % 16);
            8, 9, 10: res = (a + s) & 32'hFFFF;
            11: begin res = tgt; taken = (a == b); end
            12: begin res = tgt; taken = (a != b); end
            13: begin p = longint'(a) * longint'(b); res = int'(p & 64'hFFFF); end
            default: ctrl = 0;
        endcase
    endfunction

    // Model state: what the output stage must hold, plus one outstanding multiply.
    bit m_valid = 1'b0;
    bit m_ten   = 1'b0;
    bit m_pend  = 1'b0;
    int m_res = 0, m_rd = 0, m_dest = 0, m_ctrl = 0, m_tgt = 0;
    int m_left = 0, m_prod = 0, m_pdest = 0, m_preg2 = 0;

    always @(posedge clk) begin
        bit mld, macc, delivered, tk;
        int r, c, t;
        if (reset) begin
            m_valid = 0; m_ten = 0; m_pend = 0; m_left = 0;
            m_res = 0; m_rd = 0; m_dest = 0; m_ctrl = 0; m_tgt = 0;
        end else begin
            mld       = !m_valid || ma_ready;
            macc      = id_valid && !m_pend && mld;
            delivered = 0;
            m_ten     = 0;
            if (m_pend && m_left == 0 && mld) begin
                m_valid = 1; m_res = m_prod; m_rd = m_preg2; m_dest = m_pdest; m_ctrl = 13;
                m_pend = 0; delivered = 1;
            end else if (m_pend && m_left > 0) begin
                m_left--;
            end
            if (macc) begin
                golden(int'(CTRL_ID), int'(REG1_DATA_ID), int'(REG2_DATA_ID), int'(IMMEDIATE_ID),
                       int'(NPC_ID), r, c, t, tk);
                if (CTRL_ID == 4'd13) begin
                    m_pend = 1; m_left = 16; m_prod = r;
                    m_pdest = int'(DEST_REG_INDEX_ID); m_preg2 = int'(REG2_DATA_ID);
                    m_valid = 0;
                end else begin
                    m_valid = 1; m_res = r; m_rd = int'(REG2_DATA_ID);
                    m_dest = int'(DEST_REG_INDEX_ID); m_ctrl = c;
                    if (CTRL_ID == 4'd11 || CTRL_ID == 4'd12) begin
                        m_tgt = t; m_ten = tk;
                    end
                end
            end else if (!delivered && mld) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("m_ex_ready", 32'(ex_ready), 32'(!m_pend && (!m_valid || ma_ready)));
        chk("m_target_en", 32'(TARGET_EN), 32'(m_ten));
        chk("m_target", 32'(TARGET), m_tgt);
        if (m_valid) begin
            chk("m_res", 32'(RES_EX), m_res);
            chk("m_reg_data", 32'(REG_DATA_EX), m_rd);
            chk("m_dest", 32'(DEST_REG_INDEX_EX), m_dest);
            chk("m_ctrl", 32'(CTRL_EX), m_ctrl);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] rd, input logic [6:0] imm, input logic [15:0] npc);
        bit got;
        bit rdy;
        CTRL_ID = op; REG1_DATA_ID = a; REG2_DATA_ID = b;
        DEST_REG_INDEX_ID = rd; IMMEDIATE_ID = imm; NPC_ID = npc;
        id_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            rdy = ex_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
            else ma_ready = 1'b1;
        end
        chk("accept", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [6:0]  imm;
        logic [15:0] npc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int stale;
        vecs[0]  = '{4'd2,  16'h0000, 16'h0001, 7'h00, 16'h0000, 16'hFFFF};
        vecs[1]  = '{4'd3,  16'hF0F0, 16'h0FF0, 7'h00, 16'h0000, 16'h00F0};
        vecs[2]  = '{4'd4,  16'hF000, 16'h000F, 7'h00, 16'h0000, 16'hF00F};
        vecs[3]  = '{4'd7,  16'h8000, 16'h001F, 7'h00, 16'h0000, 16'h0001};
        vecs[4]  = '{4'd9,  16'h1000, 16'h0000, 7'h40, 16'h0000, 16'h0FC0};
        vecs[5]  = '{4'd10, 16'h2000, 16'hBEEF, 7'h03, 16'h0000, 16'h2003};
        vecs[6]  = '{4'd14, 16'h1234, 16'h5678, 7'h11, 16'h0000, 16'h0000};
        vecs[7]  = '{4'd13, 16'hFFFF, 16'hFFFF, 7'h00, 16'h0000, 16'h0001};
        vecs[8]  = '{4'd12, 16'h0001, 16'h0002, 7'h05, 16'h0020, 16'h0025};
        vecs[9]  = '{4'd13, 16'h1234, 16'h0000, 7'h00, 16'h0000, 16'h0000};
        vecs[10] = '{4'd0,  16'hAAAA, 16'h5555, 7'h00, 16'h0000, 16'h0000};
        vecs[11] = '{4'd6,  16'h00FF, 16'h0004, 7'h00, 16'h0000, 16'h0FF0};

        reset = 1'b1; id_valid = 1'b0; ma_ready = 1'b1;
        NPC_ID = '0; REG1_DATA_ID = '0; REG2_DATA_ID = '0;
        DEST_REG_INDEX_ID = '0; IMMEDIATE_ID = '0; CTRL_ID = '0;
        tick(); tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_res", 32'(RES_EX), 32'd0);
        chk("rst_ctrl", 32'(CTRL_EX), 32'd0);
        chk("rst_target_en", 32'(TARGET_EN), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        tick();

        // ADD overflow into the sign bit
        issue(4'd1, 16'h7FFF, 16'h0001, 5'd3, 7'h00, 16'h0000);
        chk("add_res", 32'(RES_EX), 32'h8000);
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_ctrl", 32'(CTRL_EX), 32'd1);
        // SLL uses only the low four bits of REG2
        issue(4'd6, 16'h0001, 16'h0013, 5'd4, 7'h00, 16'h0000);
        chk("sll_res", 32'(RES_EX), 32'h0008);
        // ADDI with imm = -1
        issue(4'd8, 16'h0005, 16'h0000, 5'd5, 7'h7F, 16'h0000);
        chk("addi_res", 32'(RES_EX), 32'h0004);
        // BEQ taken, backward target
        issue(4'd11, 16'h0042, 16'h0042, 5'd0, 7'h7E, 16'h0010);
        chk("beq_target", 32'(TARGET), 32'h000E);
        chk("beq_target_en", 32'(TARGET_EN), 32'd1);
        chk("beq_ctrl", 32'(CTRL_EX), 32'd11);
        // BNE with equal operands is not taken; also ends the BEQ pulse after one cycle
        issue(4'd12, 16'h0042, 16'h0042, 5'd0, 7'h7E, 16'h0010);
        chk("bne_target_en", 32'(TARGET_EN), 32'd0);
        chk("bne_valid", 32'(ex_valid), 32'd1);

        // Backpressure: hold ADD result for three cycles while an XOR waits
        issue(4'd1, 16'h1234, 16'h1111, 5'd6, 7'h00, 16'h0000);
        ma_ready = 1'b0;
        CTRL_ID = 4'd5; REG1_DATA_ID = 16'h00FF; REG2_DATA_ID = 16'h0F0F; DEST_REG_INDEX_ID = 5'd8;
        id_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ex_ready", 32'(ex_ready), 32'd0);
            chk("bp_res_frozen", 32'(RES_EX), 32'h2345);
            chk("bp_dest_frozen", 32'(DEST_REG_INDEX_EX), 32'd6);
            tick();
        end
        ma_ready = 1'b1;
        @(negedge clk);
        chk("drain_accept_rdy", 32'(ex_ready), 32'd1);
        tick();
        chk("drain_accept_res", 32'(RES_EX), 32'h0FF0);
        chk("drain_accept_ctrl", 32'(CTRL_EX), 32'd5);
        id_valid = 1'b0;

        // MUL: ready held low while busy, product 17 cycles after accept
        issue(4'd13, 16'h0123, 16'h0045, 5'd7, 7'h00, 16'h0000);
        id_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("mul_busy_rdy", 32'(ex_ready), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("mul_not_early", 32'(ex_valid), 32'd0);
        tick();
        chk("mul_res", 32'(RES_EX), 32'h4E6F);
        chk("mul_valid", 32'(ex_valid), 32'd1);
        chk("mul_dest", 32'(DEST_REG_INDEX_EX), 32'd7);
        chk("mul_ctrl", 32'(CTRL_EX), 32'd13);

        // Reset in the middle of a MUL abandons it
        issue(4'd13, 16'h00FF, 16'h0002, 5'd9, 7'h00, 16'h0000);
        id_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("mrst_valid", 32'(ex_valid), 32'd0);
        chk("mrst_res", 32'(RES_EX), 32'd0);
        chk("mrst_dest", 32'(DEST_REG_INDEX_EX), 32'd0);
        chk("mrst_ctrl", 32'(CTRL_EX), 32'd0);
        chk("mrst_target", 32'(TARGET), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_ready", 32'(ex_ready), 32'd1);
        stale = 0;
        repeat (25) begin
            @(negedge clk);
            if (ex_valid) stale++;
        end
        chk("no_stale_product", 32'(stale), 32'd0);
        tick();

        // Mixed table with intermittent backpressure
        for (int i = 0; i < 12; i++) begin
            ma_ready = (i % 3) != 2;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].imm, vecs[i].npc);
            if (vecs[i].op != 4'd13) begin
                chk("tbl_res", 32'(RES_EX), 32'(vecs[i].exp));
            end else begin
                id_valid = 1'b0;
                ma_ready = 1'b1;
                repeat (17) tick();
                chk("tbl_mul_res", 32'(RES_EX), 32'(vecs[i].exp));
            end
        end
        id_valid = 1'b0;
        ma_ready = 1'b1;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
